// File: rtl/fifo_uart_tx_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO-draining UART transmitter:
//   state_t           - transmitter FSM states (3-bit encoding)
//   TX_IDLE           - level of the serial line when nothing is being sent
//   START_BIT         - level of the start bit
//   STOP_BIT          - level of the stop bit
//   B_DEF             - default data width (must match the FIFO)
//   CLKS_PER_BIT_DEF  - default bit period in clocks (50 MHz / 115200)
//   CNT_W_DEF         - default bit-period counter width
// -----------------------------------------------------------------------------
package fifo_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LATCH = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  localparam logic TX_IDLE   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int B_DEF            = 8;
  localparam int CLKS_PER_BIT_DEF = 434;
  localparam int CNT_W_DEF        = 9;

endpackage : fifo_pkg

// File: rtl/fifo_uart_tx_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fifo_uart_tx_if
// Bundles the FIFO read port, the enable input and the serial-side outputs of
// the transmitter.
//   en          - transmit enable (sampled only while idle)
//   fifo_empty  - FIFO empty flag
//   fifo_rdata  - FIFO read data, valid the cycle after fifo_rd
//   fifo_rd     - single-cycle pop request
//   tx          - serial line, idles high
//   busy        - transmitter not idle
//   frames_sent - completed-frame count, wraps modulo 256
// Modports:
//   master - the transmitter (drives fifo_rd/tx/busy/frames_sent)
//   slave  - the FIFO / environment side
// -----------------------------------------------------------------------------
interface fifo_uart_tx_if
  import fifo_pkg::*;
#(
  parameter int B = B_DEF
);

  logic         en;
  logic         fifo_empty;
  logic [B-1:0] fifo_rdata;
  logic         fifo_rd;
  logic         tx;
  logic         busy;
  logic [7:0]   frames_sent;

  modport master (
    input  en,
    input  fifo_empty,
    input  fifo_rdata,
    output fifo_rd,
    output tx,
    output busy,
    output frames_sent
  );

  modport slave (
    output en,
    output fifo_empty,
    output fifo_rdata,
    input  fifo_rd,
    input  tx,
    input  busy,
    input  frames_sent
  );

endinterface : fifo_uart_tx_if

// File: rtl/fifo_uart_tx_baud_tick.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// baud_tick
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 and wraps, producing a one-cycle
// tick on the last cycle of every bit period.
//   clk      - system clock, rising edge
//   n_reset  - asynchronous active-low reset
//   clr_cnt  - hold the counter at zero (used while the transmitter is not
//              serialising, so every bit period starts cleanly)
//   tick     - high on the last cycle of each bit period
// -----------------------------------------------------------------------------
module baud_tick
  import fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic clk,
  input  logic n_reset,
  input  logic clr_cnt,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST_CNT);
  assign tick   = w_last && !clr_cnt;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_cnt <= '0;
    end else if (clr_cnt || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule : baud_tick

// File: rtl/fifo_uart_tx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fifo_uart_tx
// Drain end of the button-driven byte FIFO. Whenever transmission is enabled
// and the FIFO holds data, pops one byte and sends it as an 8N1 frame
// (start bit, B data bits LSB first, stop bit) on the tx line.
// Ports:
//   clk      - system clock, rising edge
//   n_reset  - asynchronous active-low reset
//   bus      - fifo_uart_tx_if.master:
//                en, fifo_empty, fifo_rdata (inputs)
//                fifo_rd, tx, busy, frames_sent (registered outputs)
// Timing from an idle cycle that sees en=1 and a non-empty FIFO (cycle 0):
//   fifo_rd in cycle 1, data captured in cycle 2, start bit from cycle 3.
// -----------------------------------------------------------------------------
module fifo_uart_tx
  import fifo_pkg::*;
#(
  parameter int B            = B_DEF,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           n_reset,
  fifo_uart_tx_if.master bus
);

  localparam int                IDX_W    = (B > 1) ? $clog2(B) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(B - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [B-1:0]     r_shift;
  logic [B-1:0]     w_shift_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             r_tx;
  logic             w_tx_nxt;
  logic             r_fifo_rd;
  logic             r_busy;
  logic [7:0]       r_frames;
  logic             w_frame_done;
  logic             w_tick;
  logic             w_clr_cnt;

  // The bit timer only runs while serialising; holding it at zero through
  // IDLE/READ/LATCH makes the start bit begin with a fresh count. Inside the
  // serial states every state change happens on tick, where the counter
  // wraps to zero by itself.
  assign w_clr_cnt = (r_state == IDLE) || (r_state == READ) || (r_state == LATCH);

  baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud_tick (
    .clk     (clk),
    .n_reset (n_reset),
    .clr_cnt (w_clr_cnt),
    .tick    (w_tick)
  );

  // State register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, datapath next values and next output levels
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_idx_nxt    = r_idx;
    w_frame_done = 1'b0;
    w_tx_nxt     = TX_IDLE;

    case (r_state)
      IDLE: begin
        if (bus.en && !bus.fifo_empty) begin
          w_state_nxt = READ;
        end
      end
      READ: begin
        w_state_nxt = LATCH;
      end
      LATCH: begin
        // fifo_rdata is valid now, one cycle after the pop.
        w_shift_nxt = bus.fifo_rdata;
        w_idx_nxt   = '0;
        w_state_nxt = START;
      end
      START: begin
        if (w_tick) begin
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_shift_nxt = r_shift >> 1;
          if (r_idx == LAST_IDX) begin
            w_idx_nxt   = '0;
            w_state_nxt = STOP;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          w_frame_done = 1'b1;
          w_state_nxt  = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Outputs are registered, so the line level is decided from where the
    // FSM is going; the bit on the wire in DATA is always shift[0].
    case (w_state_nxt)
      START:   w_tx_nxt = START_BIT;
      DATA:    w_tx_nxt = w_shift_nxt[0];
      STOP:    w_tx_nxt = STOP_BIT;
      default: w_tx_nxt = TX_IDLE;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_shift   <= '0;
      r_idx     <= '0;
      r_tx      <= TX_IDLE;
      r_fifo_rd <= 1'b0;
      r_busy    <= 1'b0;
      r_frames  <= 8'd0;
    end else begin
      r_shift   <= w_shift_nxt;
      r_idx     <= w_idx_nxt;
      r_tx      <= w_tx_nxt;
      r_fifo_rd <= (w_state_nxt == READ);
      r_busy    <= (w_state_nxt != IDLE);
      if (w_frame_done) begin
        r_frames <= r_frames + 8'd1;
      end
    end
  end

  assign bus.fifo_rd     = r_fifo_rd;
  assign bus.tx          = r_tx;
  assign bus.busy        = r_busy;
  assign bus.frames_sent = r_frames;

endmodule : fifo_uart_tx

// File: tb/tb_fifo_uart_tx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
// Bench for fifo_uart_tx with CLKS_PER_BIT=4, B=8. The bench plays the FIFO
// (a queue that pops on fifo_rd and presents data the following cycle) and
// predicts every frame as the ideal 8N1 waveform of the byte it expects next.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

  localparam int B     = 8;
  localparam int CPB   = 4;
  localparam int CNT_W = 3;
  localparam int FRAME = (B + 2) * CPB;

  logic clk     = 1'b0;
  logic n_reset = 1'b0;

  always #5 clk = ~clk;

  fifo_uart_tx_if #(.B(B)) bus ();

  fifo_uart_tx #(
    .B            (B),
    .CLKS_PER_BIT (CPB),
    .CNT_W        (CNT_W)
  ) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  int         n_vec      = 0;
  int         n_err      = 0;
  int         cyc        = 0;
  int         rd_pulses  = 0;
  int         exp_frames = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];

  // Ideal line waveform of one frame, one entry per clock.
  function automatic logic [FRAME-1:0] frame_wave(input logic [7:0] b);
    logic [B+1:0]     bits;
    logic [FRAME-1:0] w;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < FRAME; i++) w[i] = bits[i / CPB];
    return w;
  endfunction

  // One clock; sample point is 1 ns after the rising edge. The FIFO model
  // reacts to a pop by presenting the next byte for the following cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.fifo_rd === 1'b1) begin
      rd_pulses++;
      n_vec++;
      if (fifo_q.size() == 0) begin
        n_err++;
        $display("FAIL pop_on_empty: fifo_rd=1 at cycle %0d with model depth 0, required depth > 0", cyc);
      end else begin
        bus.fifo_rdata = fifo_q.pop_front();
      end
      bus.fifo_empty = (fifo_q.size() == 0);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
    bus.fifo_empty = 1'b0;
  endtask

  // Waits (bounded) for a start bit, then records FRAME cycles of the line.
  // en is dropped at cycle offset en_off_at when that is >= 0.
  task automatic rx_frame(input int en_off_at, output logic [FRAME-1:0] line,
                          output int t_start, output bit ok);
    int budget;
    budget  = 300;
    line    = '1;
    t_start = -1;
    ok      = 1'b1;
    while (bus.tx !== 1'b0 && budget > 0) begin
      tick();
      budget--;
    end
    if (bus.tx !== 1'b0) begin
      n_vec++;
      n_err++;
      ok = 1'b0;
      $display("FAIL rx_timeout: tx=%b after 300 cycles, required a start bit 0", bus.tx);
      return;
    end
    t_start = cyc;
    for (int i = 0; i < FRAME; i++) begin
      line[i] = bus.tx;
      if (i == en_off_at) bus.en = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    int bad_tx, bad_rd, bad_busy, bad_cnt;
    bad_tx = 0; bad_rd = 0; bad_busy = 0; bad_cnt = 0;
    bus.en         = 1'b1;
    bus.fifo_empty = 1'b1;
    bus.fifo_rdata = '0;
    n_reset        = 1'b0;
    repeat (3) tick();
    n_vec++;
    if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.fifo_rd !== 1'b0 || bus.frames_sent !== 8'd0) begin
      n_err++;
      $display("FAIL reset_values: tx=%b busy=%b fifo_rd=%b frames_sent=%0d, required 1 0 0 0",
               bus.tx, bus.busy, bus.fifo_rd, bus.frames_sent);
    end
    n_reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.tx !== 1'b1) bad_tx++;
      if (bus.fifo_rd !== 1'b0) bad_rd++;
      if (bus.busy !== 1'b0) bad_busy++;
      if (bus.frames_sent !== 8'd0) bad_cnt++;
    end
    n_vec++;
    if (bad_tx != 0) begin n_err++; $display("FAIL empty_tx: %0d cycles with tx!=1, required 0", bad_tx); end
    n_vec++;
    if (bad_rd != 0) begin n_err++; $display("FAIL empty_rd: %0d cycles with fifo_rd!=0, required 0", bad_rd); end
    n_vec++;
    if (bad_busy != 0) begin n_err++; $display("FAIL empty_busy: %0d cycles with busy!=0, required 0", bad_busy); end
    n_vec++;
    if (bad_cnt != 0) begin n_err++; $display("FAIL empty_count: %0d cycles with frames_sent!=0, required 0", bad_cnt); end
  endtask

  task automatic test_single();
    logic [FRAME-1:0] line;
    logic [7:0]       eb;
    int               t0, ts, rd0;
    bit               ok;
    rd0 = rd_pulses;
    push(8'hA5);
    t0 = cyc;
    tick();
    n_vec++;
    if (bus.fifo_rd !== 1'b1 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_rd_c1: fifo_rd=%b busy=%b, required 1 1", bus.fifo_rd, bus.busy);
    end
    tick();
    n_vec++;
    if (bus.fifo_rd !== 1'b0 || bus.tx !== 1'b1) begin
      n_err++;
      $display("FAIL single_c2: fifo_rd=%b tx=%b, required 0 1", bus.fifo_rd, bus.tx);
    end
    tick();
    n_vec++;
    if (bus.tx !== 1'b0) begin
      n_err++;
      $display("FAIL single_tx_c3: tx=%b, required 0", bus.tx);
    end
    rx_frame(-1, line, ts, ok);
    if (ok) begin
      eb = exp_q.pop_front();
      n_vec++;
      if (ts != t0 + 3) begin n_err++; $display("FAIL single_start: start at +%0d, required +3", ts - t0); end
      n_vec++;
      if (line !== frame_wave(eb)) begin
        n_err++;
        $display("FAIL single_wave: line=%h, required %h", line, frame_wave(eb));
      end
      exp_frames = (exp_frames + 1) % 256;
      n_vec++;
      if (bus.busy !== 1'b0 || bus.frames_sent !== 8'(exp_frames) || cyc != t0 + 43) begin
        n_err++;
        $display("FAIL single_done: busy=%b frames_sent=%0d at +%0d, required 0 %0d at +43",
                 bus.busy, bus.frames_sent, cyc - t0, exp_frames);
      end
    end
    n_vec++;
    if (rd_pulses - rd0 != 1) begin n_err++; $display("FAIL single_pops: %0d pops, required 1", rd_pulses - rd0); end
  endtask

  task automatic test_back_to_back();
    logic [FRAME-1:0] line;
    logic [7:0]       eb;
    int               ts, prev_ts, rd0;
    bit               ok;
    rd0     = rd_pulses;
    prev_ts = -1;
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    for (int n = 0; n < 3; n++) begin
      rx_frame(-1, line, ts, ok);
      if (!ok) break;
      eb = exp_q.pop_front();
      exp_frames = (exp_frames + 1) % 256;
      n_vec++;
      if (line !== frame_wave(eb)) begin
        n_err++;
        $display("FAIL b2b_wave[%0d]: line=%h, required %h", n, line, frame_wave(eb));
      end
      if (prev_ts >= 0) begin
        n_vec++;
        if (ts - (prev_ts + FRAME) != 3) begin
          n_err++;
          $display("FAIL b2b_gap[%0d]: %0d idle cycles, required 3", n, ts - (prev_ts + FRAME));
        end
      end
      prev_ts = ts;
    end
    n_vec++;
    if (rd_pulses - rd0 != 3) begin n_err++; $display("FAIL b2b_pops: %0d pops, required 3", rd_pulses - rd0); end
    n_vec++;
    if (bus.frames_sent !== 8'(exp_frames)) begin
      n_err++;
      $display("FAIL b2b_count: frames_sent=%0d, required %0d", bus.frames_sent, exp_frames);
    end
  endtask

  task automatic test_en_drop();
    logic [FRAME-1:0] line;
    logic [7:0]       eb, b2;
    int               ts, c0, rd0, bad_line;
    bit               ok;
    b2 = 8'($urandom_range(0, 255));
    push(8'h55);
    push(b2);
    // Offset 18 is the middle of data bit 3.
    rx_frame(18, line, ts, ok);
    if (!ok) return;
    eb = exp_q.pop_front();
    exp_frames = (exp_frames + 1) % 256;
    n_vec++;
    if (line !== frame_wave(eb)) begin
      n_err++;
      $display("FAIL endrop_wave: line=%h, required %h", line, frame_wave(eb));
    end
    rd0      = rd_pulses;
    bad_line = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) bad_line++;
    end
    n_vec++;
    if (rd_pulses - rd0 != 0) begin n_err++; $display("FAIL endrop_pops: %0d pops with en=0, required 0", rd_pulses - rd0); end
    n_vec++;
    if (bad_line != 0) begin n_err++; $display("FAIL endrop_idle: %0d non-idle cycles with en=0, required 0", bad_line); end
    bus.en = 1'b1;
    c0 = cyc;
    rx_frame(-1, line, ts, ok);
    if (!ok) return;
    eb = exp_q.pop_front();
    exp_frames = (exp_frames + 1) % 256;
    n_vec++;
    if (ts != c0 + 3) begin n_err++; $display("FAIL endrop_restart: start at +%0d after en, required +3", ts - c0); end
    n_vec++;
    if (line !== frame_wave(eb)) begin
      n_err++;
      $display("FAIL endrop_wave2: line=%h, required %h", line, frame_wave(eb));
    end
  endtask

  task automatic test_reset_mid();
    logic [FRAME-1:0] line, w;
    logic [7:0]       eb;
    int               ts, c0, budget;
    bit               ok;
    push(8'hC3);
    push(8'h5A);
    budget = 300;
    while (bus.tx !== 1'b0 && budget > 0) begin tick(); budget--; end
    n_vec++;
    if (bus.tx !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_start: tx=%b, required start bit 0", bus.tx);
      return;
    end
    ts = cyc;
    w  = frame_wave(exp_q.pop_front());
    repeat (25) tick();
    n_vec++;
    if (bus.tx !== w[25]) begin n_err++; $display("FAIL rstmid_bit5: tx=%b, required %b", bus.tx, w[25]); end
    n_reset = 1'b0;
    #1;
    exp_frames = 0;
    n_vec++;
    if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.frames_sent !== 8'd0) begin
      n_err++;
      $display("FAIL rstmid_async: tx=%b busy=%b frames_sent=%0d, required 1 0 0",
               bus.tx, bus.busy, bus.frames_sent);
    end
    repeat (2) tick();
    n_reset = 1'b1;
    c0 = cyc;
    rx_frame(-1, line, ts, ok);
    if (!ok) return;
    eb = exp_q.pop_front();
    exp_frames = (exp_frames + 1) % 256;
    n_vec++;
    if (ts != c0 + 3) begin n_err++; $display("FAIL rstmid_restart: start at +%0d after release, required +3", ts - c0); end
    n_vec++;
    if (line !== frame_wave(eb)) begin
      n_err++;
      $display("FAIL rstmid_wave: line=%h, required %h", line, frame_wave(eb));
    end
    n_vec++;
    if (bus.frames_sent !== 8'(exp_frames)) begin
      n_err++;
      $display("FAIL rstmid_count: frames_sent=%0d, required %0d", bus.frames_sent, exp_frames);
    end
  endtask

  task automatic test_random();
    logic [FRAME-1:0] line;
    logic [7:0]       eb;
    int               ts, c0;
    bit               ok;
    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(0, 5)) tick();
      push(8'($urandom_range(0, 255)));
      c0 = cyc;
      rx_frame(-1, line, ts, ok);
      if (!ok) return;
      eb = exp_q.pop_front();
      exp_frames = (exp_frames + 1) % 256;
      n_vec++;
      if (ts != c0 + 3 || line !== frame_wave(eb)) begin
        n_err++;
        $display("FAIL random[%0d]: start +%0d line=%h, required +3 %h", n, ts - c0, line, frame_wave(eb));
      end
      n_vec++;
      if (bus.frames_sent !== 8'(exp_frames)) begin
        n_err++;
        $display("FAIL random_count[%0d]: frames_sent=%0d, required %0d", n, bus.frames_sent, exp_frames);
      end
    end
  endtask

  task automatic test_wrap();
    logic [FRAME-1:0] line;
    logic [7:0]       eb, base;
    int               ts;
    bit               ok;
    n_reset = 1'b0;
    repeat (2) tick();
    n_reset    = 1'b1;
    exp_frames = 0;
    base = 8'($urandom_range(0, 255));
    for (int i = 0; i < 256; i++) push(base + 8'(i));
    for (int n = 0; n < 256; n++) begin
      rx_frame(-1, line, ts, ok);
      if (!ok) return;
      eb = exp_q.pop_front();
      exp_frames = (exp_frames + 1) % 256;
      n_vec++;
      if (line !== frame_wave(eb)) begin
        n_err++;
        $display("FAIL wrap_wave[%0d]: line=%h, required %h", n, line, frame_wave(eb));
      end
      n_vec++;
      if (bus.frames_sent !== 8'(exp_frames)) begin
        n_err++;
        $display("FAIL wrap_count[%0d]: frames_sent=%0d, required %0d", n, bus.frames_sent, exp_frames);
      end
    end
    n_vec++;
    if (bus.frames_sent !== 8'd0) begin
      n_err++;
      $display("FAIL wrap_zero: frames_sent=%0d after 256 frames, required 0", bus.frames_sent);
    end
  endtask

  initial begin
    bus.en         = 1'b1;
    bus.fifo_empty = 1'b1;
    bus.fifo_rdata = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_en_drop();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at 2 ms, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_fifo_uart_tx

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Read-side consumer for the button-driven byte FIFO. It pops one byte at a time whenever the FIFO is non-empty and transmission is enabled. Each byte is serialised as an 8N1 asynchronous frame on a single TX line to the board's serial/debug pin. It is the drain end of the FIFO: the FIFO's writer is the debounced write button, and this block is its reader.

Parameters:
B, 8, data width in bits; must equal the FIFO's B.
CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal range is 2 or more.
CNT_W, 9, width of the bit-period counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
clk  in  1  system clock, rising-edge.
n_reset  in  1  asynchronous, active-low reset.
en  in  1  transmit enable; sampled only in IDLE.
fifo_empty  in  1  FIFO empty flag.
fifo_rdata  in  B  FIFO read data; valid in the cycle after fifo_rd.
fifo_rd  out  1  single-cycle pop request to the FIFO.
tx  out  1  serial line; idles high.
busy  out  1  high whenever the FSM is not in IDLE.
frames_sent  out  8  count of completed frames; wraps modulo 256.

Behaviour:
- Clock and reset: one clock, clk. n_reset is asynchronous, active-low. All state resets to the values below; no other reset source exists.
- Reset values: tx=1, fifo_rd=0, busy=0, frames_sent=0, FSM=IDLE, bit counter=0, bit index=0, shift register=0.
- Registered outputs: all outputs come straight from flops; no combinational path from inputs to outputs.
- FSM states, with transitions and outputs:
  - IDLE: tx=1. If en=1 and fifo_empty=0, next state is READ; otherwise stay in IDLE.
  - READ: exactly 1 cycle; fifo_rd=1 (Moore output, high only in this state). Next state is LATCH.
  - LATCH: exactly 1 cycle; capture fifo_rdata into the shift register. Next state is START.
  - START: tx=0 for CLKS_PER_BIT cycles. Then next state is DATA.
  - DATA: shift out B bits, LSB first, each bit held CLKS_PER_BIT cycles. After bit B-1, next state is STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the last cycle, frames_sent increments and next state is IDLE.
- Latency: if IDLE sees the condition in cycle 0, fifo_rd=1 in cycle 1, data is captured in cycle 2, and tx falls in cycle 3.
- Frame length: (B+2)*CLKS_PER_BIT cycles. Minimum idle-high gap between back-to-back frames is 3 cycles (IDLE+READ+LATCH).
- Bit counter: counts 0..CLKS_PER_BIT-1, resets to 0 on every state change, and wraps within a bit period. The bit index has width clog2(B).
- en deasserted mid-frame: the current frame completes, and no new pop occurs.
- fifo_empty rising during READ/LATCH: ignored; the pop already issued is honoured and the byte is sent.
- The block never pops while fifo_empty=1. It never issues more than one fifo_rd per frame.
- Reset mid-frame: tx goes to 1 immediately (asynchronously). The frame is abandoned, the byte in the shift register is lost, and frames_sent clears.
- frames_sent at 255 wraps to 0 on the next completed frame.

Decomposition:
- Shared package fifo_pkg holds:
  - the state enum (IDLE, READ, LATCH, START, DATA, STOP), 3-bit encoding;
  - TX_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1;
  - default B and CLKS_PER_BIT.
- One sub-module, baud_tick:
  - parameters CLKS_PER_BIT and CNT_W;
  - inputs clr_cnt, and clk/n_reset;
  - output tick, a single-cycle pulse on the last cycle of each bit period.
  The FSM advances bits and states on tick.

Test Plan (CLKS_PER_BIT=4, B=8):
1. Reset, en=1, fifo_empty=1 for 50 cycles -> tx=1, fifo_rd never asserted, busy=0, frames_sent=0.
2. Single byte 0xA5 (fifo_empty falls at cycle 0) -> fifo_rd high in cycle 1 only; tx falls in cycle 3; line reads 0,1,0,1,0,0,1,0,1,1 (LSB first), each bit 4 cycles; busy drops and frames_sent=1 at cycle 43.
3. Three bytes 0x00, 0xFF, 0x3C queued, en=1 -> exactly 3 fifo_rd pulses; 3 idle-high cycles between frames; frames_sent=3.
4. en dropped in the middle of bit 3 of 0x55 with 1 more byte queued -> 0x55 completes; no further fifo_rd while en=0; the second byte starts 3 cycles after en returns.
5. n_reset asserted in bit 5 of 0xC3 -> tx=1 in the same cycle, busy=0, frames_sent=0; after release with fifo non-empty, the next frame starts cleanly.
6. 256 frames of incrementing data -> frames_sent wraps from 255 to 0; every decoded byte matches.
